moore_seq_detector: RTL and testbench

Parametrised Moore-model serial sequence detector. It is the next generation of the team's fixed 4-state Moore FSM labs. It samples a 1-bit serial stream and tracks how many leading bits of a programmable pattern have been matched. It flags a full match as a Moore output and keeps a saturating match count. It sits between a debounced/serialised input source and the LED/7-segment display logic.

---
 rtl/moore_seq_pkg.sv | 44 ++++
 rtl/sat_counter.sv | 18 +
 rtl/moore_seq_detector.sv | 62 ++++++
 tb/tb_moore_seq_detector.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/moore_seq_pkg.sv
// Shared helpers for the Moore sequence detector: state width and the
// elaboration-time KMP next-state function used to build the transition table.
package moore_seq_pkg;

  localparam int MAX_PAT_LEN = 16;

  function automatic int state_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // Bit m of the pattern counted from the first bit expected on the wire.
  function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pattern,
                                   input int pat_len, input int m);
    return pattern[pat_len-1-m];
  endfunction

  // Longest suffix of (matched prefix of length k, b) that is a pattern prefix,
  // capped at pat_len. From the accept state without overlap, restart from S_0.
  function automatic int next_state(input int k, input logic b,
                                    input logic [MAX_PAT_LEN-1:0] pattern,
                                    input int pat_len, input bit overlap);
    int                 kk;
    int                 best;
    bit                 ok;
    logic [MAX_PAT_LEN:0] s;
    kk = k;
    if (kk > pat_len || (kk == pat_len && !overlap)) kk = 0;
    s = '0;
    for (int i = 0; i <= MAX_PAT_LEN; i++)
      if (i < kk) s[i] = pat_bit(pattern, pat_len, i);
      else if (i == kk) s[i] = b;
    best = 0;
    for (int j = 1; j <= MAX_PAT_LEN; j++) begin
      if (j <= kk + 1 && j <= pat_len) begin
        ok = 1'b1;
        for (int m = 0; m < MAX_PAT_LEN; m++)
          if (m < j && s[kk+1-j+m] != pat_bit(pattern, pat_len, m)) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 q <= '0;
    else if (clr)              q <= '0;
    else if (inc && ~&q)       q <= q + 1'b1;
  end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector: state = matched prefix length, detect in the
// accept state, saturating count of entries into the accept state.
module moore_seq_detector
  import moore_seq_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8,
  localparam int                SW      = state_width(PAT_LEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             x_valid,
  input  logic             x_in,
  output logic [SW-1:0]    state,
  output logic             detect,
  output logic [CNT_W-1:0] match_count
);

  localparam int            NST    = 2**SW;
  localparam logic [SW-1:0] ACCEPT = SW'(PAT_LEN);

  logic [SW-1:0] ns_tab [NST][2];
  logic [SW-1:0] state_nxt;
  logic          inc;

  // Constant transition table; unreachable encodings fall back to S_0.
  for (genvar k = 0; k < NST; k++) begin : g_tab
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int NS = (k <= PAT_LEN)
        ? next_state(k, 1'(b), MAX_PAT_LEN'(PATTERN), PAT_LEN, OVERLAP != 0) : 0;
      assign ns_tab[k][b] = SW'(NS);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= '0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr)          state_nxt = '0;
    else if (x_valid) state_nxt = ns_tab[state][x_in];
  end

  always_comb begin
    detect = (state == ACCEPT);
    inc    = x_valid && !clr && (state_nxt == ACCEPT);
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (clr),
    .inc   (inc),
    .q     (match_count)
  );

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench: three detector configurations share one stimulus stream and
// are checked against a history-based suffix/prefix model.
module tb_moore_seq_detector;

  logic clock = 1'b0;
  logic reset, clr, x_valid, x_in;

  logic [2:0] st0, st1;
  logic [1:0] st2;
  logic       det0, det1, det2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  always #5 clock = ~clock;

  moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u0 (
    .clock(clock), .reset(reset), .clr(clr), .x_valid(x_valid), .x_in(x_in),
    .state(st0), .detect(det0), .match_count(cnt0));
  moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u1 (
    .clock(clock), .reset(reset), .clr(clr), .x_valid(x_valid), .x_in(x_in),
    .state(st1), .detect(det1), .match_count(cnt1));
  moore_seq_detector #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) u2 (
    .clock(clock), .reset(reset), .clr(clr), .x_valid(x_valid), .x_in(x_in),
    .state(st2), .detect(det2), .match_count(cnt2));

  // Model configuration per instance.
  int PL[3]   = '{4, 4, 2};
  int PATV[3] = '{11, 11, 3};
  int OVL[3]  = '{1, 0, 1};
  int CMAX[3] = '{255, 255, 3};

  typedef struct packed {
    logic [2:0][4:0]  st;
    logic [2:0][15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  bit   hist[3][$];
  int   mst[3];
  int   mcnt[3];
  int   n_pass = 0;
  int   n_total = 0;
  event ev_async;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic compare_one();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("state0", int'(st0), int'(e.st[0]));
      chk("detect0", int'(det0), int'(e.st[0] == 5'(PL[0])));
      chk("count0", int'(cnt0), int'(e.cnt[0]));
      chk("state1", int'(st1), int'(e.st[1]));
      chk("detect1", int'(det1), int'(e.st[1] == 5'(PL[1])));
      chk("count1", int'(cnt1), int'(e.cnt[1]));
      chk("state2", int'(st2), int'(e.st[2]));
      chk("detect2", int'(det2), int'(e.st[2] == 5'(PL[2])));
      chk("count2", int'(cnt2), int'(e.cnt[2]));
    end
  endtask

  // Monitors: one samples after every clock edge, one right after an async pulse.
  initial forever begin
    @(posedge clock);
    #1 compare_one();
  end

  initial forever begin
    @(ev_async);
    #1 compare_one();
  end

  function automatic void model_clear();
    for (int d = 0; d < 3; d++) begin
      hist[d].delete();
      mst[d]  = 0;
      mcnt[d] = 0;
    end
  endfunction

  // State = longest suffix of the sampled history that equals a pattern prefix.
  function automatic void model_bit(input int d, input bit b);
    int  best;
    bit  ok;
    int  n;
    if (OVL[d] == 0 && mst[d] == PL[d]) hist[d].delete();
    hist[d].push_back(b);
    if (hist[d].size() > PL[d]) void'(hist[d].pop_front());
    n = hist[d].size();
    best = 0;
    for (int k = 1; k <= n; k++) begin
      ok = 1'b1;
      for (int m = 0; m < k; m++)
        if (hist[d][n-k+m] != PATV[d][PL[d]-1-m]) ok = 1'b0;
      if (ok) best = k;
    end
    mst[d] = best;
    if (best == PL[d] && mcnt[d] < CMAX[d]) mcnt[d]++;
  endfunction

  function automatic void push_exp();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      e.st[d]  = 5'(mst[d]);
      e.cnt[d] = 16'(mcnt[d]);
    end
    exp_q.push_back(e);
  endfunction

  task automatic step(input bit r, input bit c, input bit v, input bit b);
    reset = r; clr = c; x_valid = v; x_in = b;
    if (r || c) model_clear();
    else if (v) for (int d = 0; d < 3; d++) model_bit(d, b);
    push_exp();
    @(negedge clock);
  endtask

  task automatic bit_in(input bit b);
    step(1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'($urandom));
  endtask

  // Reset pulse placed between clock edges.
  task automatic async_pulse();
    reset = 1'b1;
    model_clear();
    push_exp();
    ->ev_async;
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; x_valid = 1'b0; x_in = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom));
    bit_in(1); bit_in(0); bit_in(1); bit_in(1);
    idle(2);
    // Overlapping stream after a clear.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0); bit_in(1); bit_in(1);
    // Gapped bits, then a clear presented with a valid 1 while in S_3.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    bit_in(1); idle(5); bit_in(0); idle(5); bit_in(1); idle(5); bit_in(1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    bit_in(1); bit_in(0); bit_in(1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    // Long run of ones drives the 2-bit counter into saturation.
    for (int i = 0; i < 8; i++) bit_in(1);
    // Async reset in S_3, then a clean match.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    bit_in(1); bit_in(0); bit_in(1);
    async_pulse();
    bit_in(1); bit_in(0); bit_in(1); bit_in(1);
    idle(1);
    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) async_pulse();
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 6));
    end
    idle(2);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
